// File: rtl/sram_master_if.sv
// Host command/response channel and SRAM port of the sram_master block.
interface sram_master_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  init_done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd_enb;
  logic [DATA_WIDTH-1:0] r_data;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, r_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, init_done,
           wr_en, addr, w_data, rd_enb
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, r_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, init_done,
           wr_en, addr, w_data, rd_enb
  );
endinterface

// File: rtl/sram_master.sv
// Single-port SRAM controller: clears the array after reset, then serves
// one host read or write command at a time with registered SRAM strobes.
module sram_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  sram_master_if.master bus
);

  typedef enum logic [2:0] {INIT, IDLE, WR, RD, RWAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_nxt;
  logic                  wr_en_q, wr_en_nxt;
  logic                  rd_enb_q, rd_enb_nxt;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_nxt;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_nxt;
  logic                  init_done_q, init_done_nxt;
  logic                  accept;
  logic                  init_last;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_ready && bus.req_valid;
  // The clear ends once the final word's strobe is actually on the bus.
  assign init_last     = wr_en_q && (addr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      addr_q      <= '0;
      w_data_q    <= '0;
      wr_en_q     <= 1'b0;
      rd_enb_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      addr_q      <= addr_nxt;
      w_data_q    <= w_data_nxt;
      wr_en_q     <= wr_en_nxt;
      rd_enb_q    <= rd_enb_nxt;
      rsp_data_q  <= rsp_data_nxt;
      rsp_addr_q  <= rsp_addr_nxt;
      init_done_q <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_last) state_nxt = IDLE;
      IDLE:    if (accept) state_nxt = bus.req_wr ? WR : RD;
      WR:      state_nxt = IDLE;
      RD:      state_nxt = RWAIT;
      RWAIT:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Strobe registers are loaded from the upcoming state so each strobe is
  // high exactly while the FSM sits in the matching state.
  always_comb begin
    init_cnt_nxt  = init_cnt;
    addr_nxt      = addr_q;
    w_data_nxt    = w_data_q;
    wr_en_nxt     = 1'b0;
    rd_enb_nxt    = 1'b0;
    rsp_data_nxt  = rsp_data_q;
    rsp_addr_nxt  = rsp_addr_q;
    init_done_nxt = init_done_q;
    case (state_nxt)
      INIT: begin
        wr_en_nxt  = 1'b1;
        addr_nxt   = init_cnt;
        w_data_nxt = '0;
        if (init_cnt != LAST_ADDR) init_cnt_nxt = init_cnt + ADDR_WIDTH'(1);
      end
      WR: begin
        wr_en_nxt  = 1'b1;
        addr_nxt   = bus.req_addr;
        w_data_nxt = bus.req_wdata;
      end
      RD: begin
        rd_enb_nxt = 1'b1;
        addr_nxt   = bus.req_addr;
      end
      IDLE: begin
        if (state == INIT) init_done_nxt = 1'b1;
      end
      RESP: begin
        // addr still holds the read address while both strobes are low.
        if (state == RWAIT) begin
          rsp_data_nxt = bus.r_data;
          rsp_addr_nxt = addr_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.init_done = init_done_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_enb    = rd_enb_q;
  assign bus.addr      = addr_q;
  assign bus.w_data    = w_data_q;

endmodule

// File: tb/tb_sram_master.sv
// Directed plus random command bench for sram_master with a behavioural
// SRAM, a reference memory model and a read-response scoreboard.
module tb_sram_master;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   overlap_cycles = 0;

  logic [7:0] mem   [16];
  logic [7:0] model [16];
  logic [7:0] rd_q;
  exp_t       sb[$];

  always #5 clk = ~clk;

  sram_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  sram_master #(.ADDR_WIDTH(4), .DEPTH(16), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM: read data appears the cycle after rd_enb.
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.addr] <= bus.w_data;
    if (bus.rd_enb) rd_q <= mem[bus.addr];
  end
  assign bus.r_data = rd_q;

  always @(negedge clk) begin
    if (bus.wr_en && bus.rd_enb) overlap_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_reset_and_init();
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 4'd3;
    bus.req_wdata = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_outputs", 32'({bus.wr_en, bus.rd_enb, bus.req_ready, bus.rsp_valid,
            bus.init_done, bus.addr, bus.w_data, bus.rsp_data, bus.rsp_addr}), 32'd0);
    end
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("init_word", 32'({bus.wr_en, bus.rd_enb, bus.rsp_valid, bus.req_ready,
            bus.init_done, bus.addr, bus.w_data}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 8'h00}));
    end
    tick();
    check("init_done", 32'({bus.init_done, bus.req_ready, bus.wr_en, bus.rd_enb}),
          32'({1'b1, 1'b1, 1'b0, 1'b0}));
    for (int j = 0; j < 16; j++) model[j] = 8'h00;
    sb.delete();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    model[a]      = d;
    check("wr_strobe", 32'({bus.wr_en, bus.rd_enb, bus.addr, bus.w_data}),
          32'({1'b1, 1'b0, a, d}));
    check("wr_busy", 32'(bus.req_ready), 32'd0);
    tick();
    check("wr_back_idle", 32'({bus.req_ready, bus.wr_en}), 32'({1'b1, 1'b0}));
  endtask

  task automatic do_read(input logic [3:0] a, input int hold);
    exp_t e;
    wait_ready();
    e.a = a;
    e.d = model[a];
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = a;
    bus.rsp_ready = (hold == 0);
    tick();
    bus.req_valid = 1'b0;
    check("rd_strobe", 32'({bus.rd_enb, bus.wr_en, bus.addr}), 32'({1'b1, 1'b0, a}));
    tick();
    check("rwait", 32'({bus.rsp_valid, bus.rd_enb, bus.wr_en, bus.req_ready}), 32'd0);
    tick();
    check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
    for (int k = 0; k < hold; k++) begin
      check("rsp_hold", 32'({bus.rsp_valid, bus.req_ready, bus.wr_en, bus.rd_enb,
            bus.rsp_addr, bus.rsp_data}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, sb[0].a, sb[0].d}));
      tick();
    end
    bus.rsp_ready = 1'b1;
    e = sb.pop_front();
    check("rsp_data", 32'(bus.rsp_data), 32'(e.d));
    check("rsp_addr", 32'(bus.rsp_addr), 32'(e.a));
    tick();
    check("rsp_done", 32'({bus.rsp_valid, bus.req_ready}), 32'({1'b0, 1'b1}));
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;

    do_reset_and_init();

    do_write(4'd5, 8'hA5);
    do_read(4'd5, 0);
    do_read(4'd9, 0);

    do_write(4'd1, 8'h11);
    do_write(4'd2, 8'h22);
    do_write(4'd3, 8'h3C);
    do_read(4'd3, 4);
    do_read(4'd2, 1);

    do_write(4'd15, 8'hFF);
    do_read(4'd15, 0);
    do_read(4'd0, 0);

    // Reset while the read strobe is on the bus.
    do_write(4'd7, 8'h77);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 4'd7;
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("abort_rd_strobe", 32'(bus.rd_enb), 32'd1);
    do_reset_and_init();
    bus.rsp_ready = 1'b0;
    do_read(4'd7, 0);
    do_read(4'd5, 0);

    // Reset partway through the clear, with init_cnt at 7.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("init_mid_addr", 32'({bus.wr_en, bus.addr}), 32'({1'b1, 4'd6}));
    do_reset_and_init();

    for (int n = 0; n < 60; n++) begin
      logic [3:0] ra;
      ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(ra, 8'($urandom));
      else do_read(ra, int'($urandom_range(0, 2)));
    end

    check("strobe_overlap", 32'(overlap_cycles), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
